// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
//
// Purpose:
//   Bundles the control and status signals of the per-turn countdown timer.
//   The game FSM or software uses the master side. The timer uses the slave
//   side.
//
// Signals:
//   load      master -> slave   capture load_val and return to IDLE
//   load_val  master -> slave   turn length, WIDTH bits
//   start     master -> slave   begin counting from IDLE, or resume from PAUSED
//   pause     master -> slave   freeze counting while running
//   count     slave  -> master  remaining value, registered
//   busy      slave  -> master  high while running or paused
//   expired   slave  -> master  one-cycle pulse when the count reaches zero
//   done      slave  -> master  level, high until the next load or reset
// ---------------------------------------------------------------------------
interface countdown_timer_if #(
    parameter int WIDTH = 4
);

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;
    logic             done;

    // The game FSM or software drives the controls and observes the status.
    modport master (
        output load,
        output load_val,
        output start,
        output pause,
        input  count,
        input  busy,
        input  expired,
        input  done
    );

    // The timer observes the controls and drives the status.
    modport slave (
        input  load,
        input  load_val,
        input  start,
        input  pause,
        output count,
        output busy,
        output expired,
        output done
    );

endinterface

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Purpose:
//   A loadable, prescaled down counter used as the per-turn timer in the
//   battleship game. It is the counterpart of up_counter. A turn length is
//   loaded and then started. The count drops by one every PRESCALE clocks.
//   Counting can be paused, for example while a shot animation plays, and
//   later resumed without losing partial prescale progress. When the count
//   reaches zero the timer pulses expired once and then holds done.
//
// Parameters:
//   WIDTH     width of count and load_val
//   PRESCALE  clocks per decrement, from 1 to 256 (8-bit prescaler)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   timer_bus  countdown_timer_if.slave
//                in : load, load_val, start, pause
//                out: count, busy, expired, done (all registered)
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    countdown_timer_if.slave      timer_bus
);

    // Reject parameter values the 8-bit prescaler cannot represent.
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("countdown_timer: PRESCALE must be in 1..256");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("countdown_timer: WIDTH must be at least 1");
    end

    localparam logic [7:0]       PRESCALE_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] COUNT_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Local copies of the interface inputs.
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             start_i;
    logic             pause_i;

    assign load_i     = timer_bus.load;
    assign load_val_i = timer_bus.load_val;
    assign start_i    = timer_bus.start;
    assign pause_i    = timer_bus.pause;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [7:0]       prescale_q, prescale_d;
    logic             expired_q,  expired_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    // State register.
    // Every status output is its own flop, so the outputs change only on a
    // clock edge. The asynchronous reset clears everything at once, without
    // waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            prescale_q <= '0;
            expired_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            expired_q  <= expired_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    // The timer takes at most one action per edge, in priority order
    // load > pause > start. A pause beats start in every state, so a start
    // that arrives together with pause does nothing. expired_d defaults to 0,
    // which makes expired a single-cycle pulse: it is set only on the edge
    // that enters DONE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        expired_d  = 1'b0;

        if (load_i) begin
            // A load aborts any activity and clears done. It never raises
            // expired.
            state_d    = IDLE;
            count_d    = load_val_i;
            prescale_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!pause_i && start_i) begin
                        if (count_q == '0) begin
                            // A zero turn length expires on the start edge.
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d    = RUN;
                            prescale_d = '0;
                        end
                    end
                end

                RUN: begin
                    if (pause_i) begin
                        state_d = PAUSED;
                    end else if (prescale_q == PRESCALE_LAST) begin
                        // The prescaler wraps on the PRESCALE-th edge spent
                        // in RUN. That edge also performs the decrement.
                        prescale_d = '0;
                        if (count_q == COUNT_ONE) begin
                            count_d   = '0;
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else if (count_q == '0) begin
                            // Defensive case: RUN is never entered with a
                            // zero count. Finish without wrapping.
                            state_d = DONE;
                        end else begin
                            count_d = count_q - COUNT_ONE;
                        end
                    end else begin
                        prescale_d = prescale_q + 8'd1;
                    end
                end

                PAUSED: begin
                    // The prescaler value is held, so on resume the partial
                    // progress toward the next decrement is kept.
                    if (!pause_i && start_i) begin
                        state_d = RUN;
                    end
                end

                DONE: begin
                    count_d = '0;
                end

                default: begin
                    state_d    = IDLE;
                    count_d    = '0;
                    prescale_d = '0;
                end
            endcase
        end
    end

    // busy and done are decoded from the next state and then registered,
    // so they are clean flop outputs that line up with the state register.
    always_comb begin
        busy_d = (state_d == RUN) || (state_d == PAUSED);
        done_d = (state_d == DONE);
    end

    assign timer_bus.count   = count_q;
    assign timer_bus.busy    = busy_q;
    assign timer_bus.expired = expired_q;
    assign timer_bus.done    = done_q;

`ifndef SYNTHESIS
    // expired is a pulse. It can never be high on two consecutive cycles.
    a_expired_single : assert property (
        @(posedge clk) disable iff (rst) expired_q |=> !expired_q
    );

    // Once finished, the remaining count reads zero.
    a_done_zero : assert property (
        @(posedge clk) disable iff (rst) done_q |-> (count_q == '0)
    );

    // The timer is never busy and done at the same time.
    a_busy_done_excl : assert property (
        @(posedge clk) disable iff (rst) !(busy_q && done_q)
    );
`endif

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable, prescaled down counter used as the per-turn timer in the battleship game. It is the complement of the existing up_counter.
- Software or game FSM loads a turn length, then starts the timer.
- The timer decrements once every PRESCALE clocks.
- It reports busy while counting and pulses expired once when it reaches zero.
- Pause and resume are supported, so a turn can be frozen during shot animation.

Parameters:
WIDTH, 4, bit width of the count value and of load_val.
PRESCALE, 4, clock cycles per decrement; legal values are 1 to 256. The prescaler register is 8 bits.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  when high, count <= load_val and the block returns to IDLE.
load_val  input  WIDTH  value captured on load.
start  input  1  begins counting from IDLE, or resumes from PAUSED.
pause  input  1  freezes counting while in RUN.
count  output  WIDTH  current remaining value, registered.
busy  output  1  high in RUN or PAUSED.
expired  output  1  single-cycle pulse on reaching zero.
done  output  1  level, high in DONE until the next load or reset.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, prescaler=0, busy=0, expired=0, done=0. These hold while rst is high, and take effect immediately, without waiting for a clock edge.
- Per-edge input priority: load > pause > start. Only one action is taken per edge.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered and change only on clk edges (rst excepted).
- IDLE:
  - load: count <= load_val, prescaler <= 0, remain in IDLE.
  - start with count != 0: go to RUN, prescaler <= 0.
  - start with count == 0: go to DONE, expired=1 for one cycle.
- RUN:
  - Each edge, prescaler increments.
  - When prescaler == PRESCALE-1: prescaler wraps to 0 and count decrements by 1.
  - First decrement occurs PRESCALE edges after the edge that accepted start.
  - If the decrement takes count from 1 to 0: go to DONE. expired is high for exactly the cycle in which count first reads 0.
  - pause: go to PAUSED. Prescaler and count hold.
  - load: abort to IDLE with the new value. No expired pulse.
- PAUSED:
  - Prescaler and count hold.
  - start: return to RUN, continuing from the held prescaler value. Partial prescale progress is not lost.
  - pause held high keeps the block paused.
  - load: go to IDLE with the new value.
- DONE:
  - done=1, count=0.
  - start and pause are ignored.
  - load: go to IDLE with done <= 0.
- No wrap-around: count never decrements below 0 and never increments.
- busy = (state == RUN || state == PAUSED).
- expired is never high for two consecutive cycles.
- load_val = 0 followed by start is legal and behaves as the count == 0 case.

Test Plan:
All scenarios use WIDTH=4, PRESCALE=2.
1. Reset: rst=1 asserted between clock edges -> count=0, busy=0, done=0, expired=0 immediately. After release, with no inputs for 5 clocks, all outputs stay 0.
2. Full countdown: load=1, load_val=5 at edge 0; start at edge 1 -> count reads 4, 3, 2, 1, 0 at edges 3, 5, 7, 9, 11. expired=1 only in the cycle after edge 11. done=1 from edge 11. busy=1 from edge 1 to edge 10.
3. Pause/resume: load 6, start, then after the first decrement (count=5) hold pause for 4 edges -> count stays 5 and busy stays 1. Deassert pause and pulse start -> decrements resume at the PRESCALE cadence; expired fires exactly once at 0.
4. Zero start: load 0, start -> DONE on the next edge, expired pulse of 1 cycle, busy never 1.
5. Abort and priority: in RUN at count=3, assert load=1, load_val=9, pause=1, start=1 on the same edge -> IDLE, count=9, busy=0, no expired. Then start alone -> counts down from 9.
6. Reset mid-run: in RUN at count=7, pulse rst for half a clock period -> immediate return to the reset values. Restarting requires a new load and start.
